// File: rtl/usb_pipe_pkg.sv
// rtl/usb_pipe_pkg.sv - shared PIPE power-control types and constants
package usb_pipe_pkg;

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } pd_state_e;

    localparam logic [2:0] RXST_DET = 3'b011;
    localparam logic [2:0] RXST_OK  = 3'b000;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        IDLE     = 3'd1,
        PD_WAIT  = 3'd2,
        DET_WAIT = 3'd3,
        DET_REL  = 3'd4
    } pwr_ctrl_state_e;

endpackage

// File: rtl/pipe_phystatus_timer.sv
// rtl/pipe_phystatus_timer.sv - PhyStatus wait counter with expire flag
module pipe_phystatus_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] r_count;

    // count enabled wait cycles; expire fires on the TIMEOUT_CYC-th one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_en && (r_count == LAST);

endmodule

// File: rtl/pipe_pwr_ctrl.sv
// rtl/pipe_pwr_ctrl.sv - PIPE PowerDown/RxDetect/TxElecIdle sequencer (optional timeout: PIPE_PWR_TIMEOUT_EN)
module pipe_pwr_ctrl
    import usb_pipe_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [1:0] RESET_PD    = 2'b10
) (
    input  logic       phy_pipe_pclk,
    input  logic       reset,
    input  logic       pd_req_valid,
    input  logic [1:0] pd_req_state,
    output logic       pd_req_ready,
    output logic       pd_done,
    input  logic       det_req,
    output logic       det_done,
    output logic       det_present,
    output logic       det_err,
    input  logic       tx_idle_req,
    output logic [1:0] cur_pd,
    output logic       err_timeout,
    output logic [1:0] phy_power_down,
    output logic       phy_tx_detrx_lpbk,
    output logic       phy_tx_elecidle,
    input  logic       phy_phy_status,
    input  logic [2:0] phy_rx_status
);
    pwr_ctrl_state_e r_state, w_state_nxt;
    logic [1:0] r_power_down, w_power_down_nxt;
    logic [1:0] r_cur_pd, w_cur_pd_nxt;
    logic       r_detrx, w_detrx_nxt;
    logic       r_pd_done, w_pd_done_nxt;
    logic       r_det_done, w_det_done_nxt;
    logic       r_det_err, w_det_err_nxt;
    logic       r_det_present, w_det_present_nxt;
    logic       r_err_timeout, w_err_timeout_nxt;
    logic       r_tx_elecidle, w_tx_elecidle_nxt;
    logic       w_waiting;
    logic       w_expire;

    assign w_waiting = (r_state == PD_WAIT) || (r_state == DET_WAIT);

`ifdef PIPE_PWR_TIMEOUT_EN
    pipe_phystatus_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk      (phy_pipe_pclk),
        .rst      (reset),
        .i_clr    (!w_waiting),
        .i_en     (w_waiting),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    // state register
    always_ff @(posedge phy_pipe_pclk or posedge reset) begin
        if (reset) r_state <= INIT;
        else       r_state <= w_state_nxt;
    end

    // next state and next values of all registered outputs
    always_comb begin
        w_state_nxt       = r_state;
        w_power_down_nxt  = r_power_down;
        w_cur_pd_nxt      = r_cur_pd;
        w_detrx_nxt       = r_detrx;
        w_pd_done_nxt     = 1'b0;
        w_det_done_nxt    = 1'b0;
        w_det_err_nxt     = 1'b0;
        w_det_present_nxt = r_det_present;
        w_err_timeout_nxt = r_err_timeout;
        case (r_state)
            INIT: begin
                if (!phy_phy_status) w_state_nxt = IDLE;
            end
            IDLE: begin
                if (pd_req_valid) begin
                    if (pd_req_state == r_cur_pd) begin
                        w_pd_done_nxt = 1'b1;
                    end else begin
                        w_power_down_nxt = pd_req_state;
                        w_state_nxt      = PD_WAIT;
                    end
                // det_req is a held level: skip the cycle its det_done is showing
                end else if (det_req && !r_det_done) begin
                    if (r_cur_pd == P2) begin
                        w_detrx_nxt = 1'b1;
                        w_state_nxt = DET_WAIT;
                    end else begin
                        w_det_done_nxt    = 1'b1;
                        w_det_err_nxt     = 1'b1;
                        w_det_present_nxt = 1'b0;
                    end
                end
            end
            PD_WAIT: begin
                if (phy_phy_status || w_expire) begin
                    w_cur_pd_nxt  = r_power_down;
                    w_pd_done_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                    if (!phy_phy_status) w_err_timeout_nxt = 1'b1;
                end
            end
            DET_WAIT: begin
                if (phy_phy_status) begin
                    w_det_present_nxt = (phy_rx_status == RXST_DET);
                    w_detrx_nxt       = 1'b0;
                    w_state_nxt       = DET_REL;
                end else if (w_expire) begin
                    w_det_present_nxt = 1'b0;
                    w_err_timeout_nxt = 1'b1;
                    w_detrx_nxt       = 1'b0;
                    w_state_nxt       = DET_REL;
                end
            end
            DET_REL: begin
                w_det_done_nxt = 1'b1;
                w_state_nxt    = IDLE;
            end
            default: w_state_nxt = INIT;
        endcase
        // electrical idle is forced whenever the link is not fully in P0 or detection is running
        if ((w_cur_pd_nxt != P0) || (w_power_down_nxt != P0) ||
            (w_state_nxt == DET_WAIT) || (w_state_nxt == DET_REL))
            w_tx_elecidle_nxt = 1'b1;
        else
            w_tx_elecidle_nxt = tx_idle_req;
    end

    // registered outputs
    always_ff @(posedge phy_pipe_pclk or posedge reset) begin
        if (reset) begin
            r_power_down  <= RESET_PD;
            r_cur_pd      <= RESET_PD;
            r_detrx       <= 1'b0;
            r_pd_done     <= 1'b0;
            r_det_done    <= 1'b0;
            r_det_err     <= 1'b0;
            r_det_present <= 1'b0;
            r_err_timeout <= 1'b0;
            r_tx_elecidle <= 1'b1;
        end else begin
            r_power_down  <= w_power_down_nxt;
            r_cur_pd      <= w_cur_pd_nxt;
            r_detrx       <= w_detrx_nxt;
            r_pd_done     <= w_pd_done_nxt;
            r_det_done    <= w_det_done_nxt;
            r_det_err     <= w_det_err_nxt;
            r_det_present <= w_det_present_nxt;
            r_err_timeout <= w_err_timeout_nxt;
            r_tx_elecidle <= w_tx_elecidle_nxt;
        end
    end

    assign pd_req_ready      = (r_state == IDLE);
    assign pd_done           = r_pd_done;
    assign det_done          = r_det_done;
    assign det_err           = r_det_err;
    assign det_present       = r_det_present;
    assign cur_pd            = r_cur_pd;
    assign err_timeout       = r_err_timeout;
    assign phy_power_down    = r_power_down;
    assign phy_tx_detrx_lpbk = r_detrx;
    assign phy_tx_elecidle   = r_tx_elecidle;

endmodule

// File: tb/tb_pipe_pwr_ctrl.sv
// tb/tb_pipe_pwr_ctrl.sv - directed self-checking bench for pipe_pwr_ctrl (optional timeout: PIPE_PWR_TIMEOUT_EN)
module tb_pipe_pwr_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pd_req_valid = 1'b0;
    logic [1:0] pd_req_state = 2'd0;
    logic       pd_req_ready;
    logic       pd_done;
    logic       det_req = 1'b0;
    logic       det_done;
    logic       det_present;
    logic       det_err;
    logic       tx_idle_req = 1'b1;
    logic [1:0] cur_pd;
    logic       err_timeout;
    logic [1:0] phy_power_down;
    logic       phy_tx_detrx_lpbk;
    logic       phy_tx_elecidle;
    logic       phy_phy_status = 1'b1;
    logic [2:0] phy_rx_status = 3'd0;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pipe_pwr_ctrl #(.TIMEOUT_CYC(16), .RESET_PD(2'b10)) dut (
        .phy_pipe_pclk     (clk),
        .reset             (rst),
        .pd_req_valid      (pd_req_valid),
        .pd_req_state      (pd_req_state),
        .pd_req_ready      (pd_req_ready),
        .pd_done           (pd_done),
        .det_req           (det_req),
        .det_done          (det_done),
        .det_present       (det_present),
        .det_err           (det_err),
        .tx_idle_req       (tx_idle_req),
        .cur_pd            (cur_pd),
        .err_timeout       (err_timeout),
        .phy_power_down    (phy_power_down),
        .phy_tx_detrx_lpbk (phy_tx_detrx_lpbk),
        .phy_tx_elecidle   (phy_tx_elecidle),
        .phy_phy_status    (phy_phy_status),
        .phy_rx_status     (phy_rx_status)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; phy_phy_status = 1'b1;
        step(2);
        checks++; if (phy_power_down !== 2'b10) $display("FAIL rst_pd got %0d exp 2", phy_power_down); else passed++;
        checks++; if (cur_pd !== 2'b10) $display("FAIL rst_cur_pd got %0d exp 2", cur_pd); else passed++;
        checks++; if ({phy_tx_elecidle, phy_tx_detrx_lpbk, pd_req_ready, pd_done, det_done, det_present, det_err, err_timeout} !== 8'b1000_0000)
            $display("FAIL rst_flags got %b exp 10000000", {phy_tx_elecidle, phy_tx_detrx_lpbk, pd_req_ready, pd_done, det_done, det_present, det_err, err_timeout});
        else passed++;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++; if (pd_req_ready !== 1'b0 || phy_power_down !== 2'b10)
                $display("FAIL init_hold cyc %0d ready %b pd %0d exp 0/2", i, pd_req_ready, phy_power_down);
            else passed++;
        end
        phy_phy_status = 1'b0;
        checks++; if (pd_req_ready !== 1'b0) $display("FAIL init_fall ready got %b exp 0", pd_req_ready); else passed++;
        step(2);
        checks++; if (pd_req_ready !== 1'b1 || phy_power_down !== 2'b10)
            $display("FAIL init_ready got %b pd %0d exp 1/2", pd_req_ready, phy_power_down);
        else passed++;
    endtask

    task automatic test_pd_to_p0;
        tx_idle_req = 1'b1;
        pd_req_valid = 1'b1; pd_req_state = 2'd0;
        step(1);
        pd_req_valid = 1'b0;
        checks++; if (phy_power_down !== 2'd0) $display("FAIL pd_write got %0d exp 0", phy_power_down); else passed++;
        checks++; if (pd_req_ready !== 1'b0 || phy_tx_elecidle !== 1'b1)
            $display("FAIL pd_wait ready %b eidle %b exp 0/1", pd_req_ready, phy_tx_elecidle);
        else passed++;
        step(7);
        checks++; if (pd_done !== 1'b0 || cur_pd !== 2'd2) $display("FAIL pd_early done %b cur %0d exp 0/2", pd_done, cur_pd); else passed++;
        phy_phy_status = 1'b1;
        step(1);
        phy_phy_status = 1'b0;
        checks++; if (pd_done !== 1'b1 || cur_pd !== 2'd0) $display("FAIL pd_done done %b cur %0d exp 1/0", pd_done, cur_pd); else passed++;
        checks++; if (phy_tx_elecidle !== 1'b1) $display("FAIL eidle_req1 got %b exp 1", phy_tx_elecidle); else passed++;
        tx_idle_req = 1'b0;
        step(1);
        checks++; if (phy_tx_elecidle !== 1'b0 || pd_done !== 1'b0) $display("FAIL eidle_req0 eidle %b done %b exp 0/0", phy_tx_elecidle, pd_done); else passed++;
        tx_idle_req = 1'b1;
        step(1);
        checks++; if (phy_tx_elecidle !== 1'b1) $display("FAIL eidle_follow got %b exp 1", phy_tx_elecidle); else passed++;
    endtask

    task automatic test_det_p0;
        det_req = 1'b1;
        step(1);
        checks++; if ({det_done, det_err, det_present, phy_tx_detrx_lpbk} !== 4'b1100)
            $display("FAIL det_p0 got %b exp 1100", {det_done, det_err, det_present, phy_tx_detrx_lpbk});
        else passed++;
        det_req = 1'b0;
        step(1);
        checks++; if ({det_done, det_err, phy_tx_detrx_lpbk} !== 3'b000)
            $display("FAIL det_p0_after got %b exp 000", {det_done, det_err, phy_tx_detrx_lpbk});
        else passed++;
    endtask

    // move to a new power state with a PhyStatus pulse after a few cycles
    task automatic go_state(input logic [1:0] tgt);
        pd_req_valid = 1'b1; pd_req_state = tgt;
        step(1);
        pd_req_valid = 1'b0;
        step(2);
        phy_phy_status = 1'b1;
        step(1);
        phy_phy_status = 1'b0;
        step(1);
    endtask

    task automatic test_det_p2(input logic [2:0] rx, input logic exp_present);
        det_req = 1'b1;
        step(1);
        for (int i = 0; i < 3; i++) begin
            checks++; if (phy_tx_detrx_lpbk !== 1'b1 || det_done !== 1'b0)
                $display("FAIL det_lpbk cyc %0d lpbk %b done %b exp 1/0", i, phy_tx_detrx_lpbk, det_done);
            else passed++;
            step(1);
        end
        phy_phy_status = 1'b1; phy_rx_status = rx;
        step(1);
        phy_phy_status = 1'b0; phy_rx_status = 3'd0;
        checks++; if (phy_tx_detrx_lpbk !== 1'b0 || det_done !== 1'b0)
            $display("FAIL det_rel lpbk %b done %b exp 0/0", phy_tx_detrx_lpbk, det_done);
        else passed++;
        step(1);
        checks++; if ({det_done, det_present, det_err} !== {1'b1, exp_present, 1'b0})
            $display("FAIL det_done got %b exp %b", {det_done, det_present, det_err}, {1'b1, exp_present, 1'b0});
        else passed++;
        det_req = 1'b0;
        step(1);
        checks++; if (det_done !== 1'b0 || det_present !== exp_present || phy_tx_detrx_lpbk !== 1'b0)
            $display("FAIL det_hold done %b pres %b lpbk %b exp 0/%b/0", det_done, det_present, phy_tx_detrx_lpbk, exp_present);
        else passed++;
    endtask

    task automatic test_back_to_back;
        pd_req_valid = 1'b1; pd_req_state = 2'd1; det_req = 1'b1;
        step(1);
        pd_req_valid = 1'b0;
        checks++; if (phy_power_down !== 2'd1 || phy_tx_detrx_lpbk !== 1'b0)
            $display("FAIL b2b_accept pd %0d lpbk %b exp 1/0", phy_power_down, phy_tx_detrx_lpbk);
        else passed++;
        step(2);
        phy_phy_status = 1'b1;
        step(1);
        phy_phy_status = 1'b0;
        checks++; if (pd_done !== 1'b1 || cur_pd !== 2'd1 || det_done !== 1'b0)
            $display("FAIL b2b_pd done %b cur %0d det %b exp 1/1/0", pd_done, cur_pd, det_done);
        else passed++;
        step(1);
        checks++; if ({det_done, det_err, det_present, phy_tx_detrx_lpbk} !== 4'b1100)
            $display("FAIL b2b_det got %b exp 1100", {det_done, det_err, det_present, phy_tx_detrx_lpbk});
        else passed++;
        det_req = 1'b0;
        step(1);
    endtask

    task automatic test_same_state;
        pd_req_valid = 1'b1; pd_req_state = 2'd1;
        step(1);
        pd_req_valid = 1'b0;
        checks++; if (pd_done !== 1'b1 || pd_req_ready !== 1'b1 || phy_power_down !== 2'd1)
            $display("FAIL same_pd done %b ready %b pd %0d exp 1/1/1", pd_done, pd_req_ready, phy_power_down);
        else passed++;
        step(1);
        checks++; if (pd_done !== 1'b0) $display("FAIL same_pd_pulse got %b exp 0", pd_done); else passed++;
    endtask

    task automatic test_timeout;
        pd_req_valid = 1'b1; pd_req_state = 2'd3;
        step(1);
        pd_req_valid = 1'b0;
`ifdef PIPE_PWR_TIMEOUT_EN
        step(15);
        checks++; if (err_timeout !== 1'b0 || pd_done !== 1'b0) $display("FAIL to_early err %b done %b exp 0/0", err_timeout, pd_done); else passed++;
        step(1);
        checks++; if (err_timeout !== 1'b1 || pd_done !== 1'b1 || cur_pd !== 2'd3)
            $display("FAIL to_fire err %b done %b cur %0d exp 1/1/3", err_timeout, pd_done, cur_pd);
        else passed++;
        step(3);
        checks++; if (err_timeout !== 1'b1 || pd_done !== 1'b0) $display("FAIL to_sticky err %b done %b exp 1/0", err_timeout, pd_done); else passed++;
`else
        step(40);
        checks++; if (err_timeout !== 1'b0 || pd_req_ready !== 1'b0 || pd_done !== 1'b0)
            $display("FAIL no_to err %b ready %b done %b exp 0/0/0", err_timeout, pd_req_ready, pd_done);
        else passed++;
        phy_phy_status = 1'b1;
        step(1);
        phy_phy_status = 1'b0;
        checks++; if (pd_done !== 1'b1 || cur_pd !== 2'd3) $display("FAIL no_to_done done %b cur %0d exp 1/3", pd_done, cur_pd); else passed++;
        step(1);
`endif
    endtask

    task automatic test_reset_mid;
        pd_req_valid = 1'b1; pd_req_state = 2'd0;
        step(1);
        pd_req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if ({phy_power_down, cur_pd, phy_tx_elecidle, err_timeout, pd_done, pd_req_ready} !== 8'b10_10_1_000)
            $display("FAIL mid_rst got %b exp 10101000", {phy_power_down, cur_pd, phy_tx_elecidle, err_timeout, pd_done, pd_req_ready});
        else passed++;
        step(1);
        rst = 1'b0;
        phy_phy_status = 1'b1;
        step(3);
        checks++; if (pd_done !== 1'b0 || pd_req_ready !== 1'b0) $display("FAIL mid_rst_init done %b ready %b exp 0/0", pd_done, pd_req_ready); else passed++;
        phy_phy_status = 1'b0;
        step(2);
        checks++; if (pd_req_ready !== 1'b1) $display("FAIL mid_rst_ready got %b exp 1", pd_req_ready); else passed++;
    endtask

    initial begin
        test_reset();
        test_pd_to_p0();
        test_det_p0();
        go_state(2'd2);
        test_det_p2(3'b011, 1'b1);
        test_det_p2(3'b000, 1'b0);
        test_back_to_back();
        test_same_state();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
